// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures how long a synchronised input stays high and
// reports the width in clock cycles and in nanoseconds over a valid/ready
// handshake. Short pulses are rejected as glitches, long ones saturate with
// an overflow flag, and rising edges seen while a result waits are flagged.
module pulse_width_meter #(
  parameter  int CYCLE_TIME = 10,
  parameter  int MAX_PERIOD = 1_000_000,
  parameter  int MIN_PERIOD = 0,
  localparam int MAX_CYCLE  = MAX_PERIOD / CYCLE_TIME,
  localparam int MIN_CYCLE  = MIN_PERIOD / CYCLE_TIME,
  localparam int CW         = $clog2(MAX_CYCLE + 1),
  localparam int NW         = $clog2(MAX_CYCLE * CYCLE_TIME + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          sig_in,
  input  logic          ready,
  output logic          valid,
  output logic [CW-1:0] width_cycles,
  output logic [NW-1:0] width_ns,
  output logic          overflow,
  output logic          missed
);

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_HIGH,
    MEASURE,
    REPORT
  } state_e;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CYCLE);
  localparam logic [NW-1:0] CT_NW   = NW'(CYCLE_TIME);
  localparam logic [NW-1:0] MAX_NS  = NW'(MAX_CYCLE * CYCLE_TIME);

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            prev_q, prev_d;
  logic [1:0]      fill_q, fill_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   width_cycles_q, width_cycles_d;
  logic [NW-1:0]   width_ns_q, width_ns_d;
  logic            overflow_q, overflow_d;
  logic            missed_q, missed_d;

  logic sig_s;
  logic sig_rise;
  logic short_pulse;
  logic at_max;

  assign sig_s       = sync2_q;
  assign sig_rise    = sig_s && !prev_q;
  // Signed compare keeps the test meaningful even when MIN_CYCLE is zero.
  assign short_pulse = int'(cnt_q) < MIN_CYCLE;
  assign at_max      = (cnt_q == MAX_CNT);

  // State register and all datapath flops; reset and disable clear alike.
  always_ff @(posedge clk) begin
    // NOTE: every flop uses non-blocking assignment so all registers update
    // together from the values sampled at the same edge.
    if (!rst_n || !enable) begin
      state_q        <= WAIT_LOW;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      prev_q         <= 1'b0;
      fill_q         <= 2'b00;
      cnt_q          <= '0;
      valid_q        <= 1'b0;
      width_cycles_q <= '0;
      width_ns_q     <= '0;
      overflow_q     <= 1'b0;
      missed_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      prev_q         <= prev_d;
      fill_q         <= fill_d;
      cnt_q          <= cnt_d;
      valid_q        <= valid_d;
      width_cycles_q <= width_cycles_d;
      width_ns_q     <= width_ns_d;
      overflow_q     <= overflow_d;
      missed_q       <= missed_d;
    end
  end

  // Next-state logic of the measurement FSM.
  always_comb begin
    // NOTE: a default assignment first means no path leaves state_d
    // unassigned, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      // fill_q marks the synchroniser as holding a real sample; the cleared
      // flops must not be mistaken for an observed low after enable rises.
      WAIT_LOW:  if (fill_q[1] && !sig_s) state_d = WAIT_HIGH;
      WAIT_HIGH: if (sig_s) state_d = MEASURE;
      MEASURE: begin
        if (sig_s) begin
          if (at_max) state_d = REPORT;
        end else if (short_pulse) begin
          state_d = WAIT_HIGH;
        end else begin
          state_d = REPORT;
        end
      end
      REPORT:    if (valid_q && ready) state_d = WAIT_LOW;
      default:   state_d = WAIT_LOW;
    endcase
  end

  // Datapath and output next values: synchroniser, counter, result latch.
  always_comb begin
    sync1_d        = sig_in;
    sync2_d        = sync1_q;
    prev_d         = sync2_q;
    fill_d         = {fill_q[0], 1'b1};
    cnt_d          = cnt_q;
    valid_d        = valid_q;
    width_cycles_d = width_cycles_q;
    width_ns_d     = width_ns_q;
    overflow_d     = overflow_q;
    missed_d       = 1'b0;
    unique case (state_q)
      WAIT_HIGH: if (sig_s) cnt_d = CW'(1);
      MEASURE: begin
        if (sig_s) begin
          if (at_max) begin
            // Saturate rather than wrap; the tail of the pulse is ignored.
            width_cycles_d = MAX_CNT;
            width_ns_d     = MAX_NS;
            overflow_d     = 1'b1;
            valid_d        = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (!short_pulse) begin
          width_cycles_d = cnt_q;
          width_ns_d     = NW'(cnt_q) * CT_NW;
          overflow_d     = 1'b0;
          valid_d        = 1'b1;
        end
      end
      REPORT: begin
        // A new pulse starting while the result waits is flagged, not timed.
        if (sig_rise) missed_d = 1'b1;
        if (valid_q && ready) valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign valid        = valid_q;
  assign width_cycles = width_cycles_q;
  assign width_ns     = width_ns_q;
  assign overflow     = overflow_q;
  assign missed       = missed_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter with CYCLE_TIME=10, MAX_PERIOD=1000,
// MIN_PERIOD=30 (MAX_CYCLE=100, MIN_CYCLE=3).
module tb_pulse_width_meter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       sig_in;
  logic       ready;
  logic       valid;
  logic [6:0] width_cycles;
  logic [9:0] width_ns;
  logic       overflow;
  logic       missed;

  int n_cmp = 0;
  int n_bad = 0;
  int rep_q[$];

  pulse_width_meter #(
    .CYCLE_TIME(10),
    .MAX_PERIOD(1000),
    .MIN_PERIOD(30)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sig_in       (sig_in),
    .ready        (ready),
    .valid        (valid),
    .width_cycles (width_cycles),
    .width_ns     (width_ns),
    .overflow     (overflow),
    .missed       (missed)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge, sample 1 time unit later, log any valid result.
  task automatic tick();
    @(posedge clk);
    #1;
    if (valid) rep_q.push_back(int'(width_cycles));
  endtask

  task automatic idle(input int n);
    sig_in = 1'b0;
    repeat (n) tick();
  endtask

  // sig_in is sampled high on exactly n edges, then driven low.
  task automatic pulse(input int n);
    sig_in = 1'b1;
    repeat (n) tick();
    sig_in = 1'b0;
  endtask

  task automatic await_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; sig_in = 1'b0; ready = 1'b0;
    repeat (3) tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", valid); end
    n_cmp++; if (width_cycles !== 7'd0) begin n_bad++; $display("FAIL reset_width: got %0d want 0", width_cycles); end
    n_cmp++; if (width_ns !== 10'd0) begin n_bad++; $display("FAIL reset_ns: got %0d want 0", width_ns); end
    n_cmp++; if (overflow !== 1'b0 || missed !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got ov=%0b missed=%0b want 0/0", overflow, missed); end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    ready = 1'b1;
    pulse(25);
    tick();  // first edge sampling low
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL basic_early: got valid=%0b want 0 after 2 edges", valid); end
    tick();
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency: got valid=%0b want 1 after 3 edges", valid); end
    n_cmp++; if (width_cycles !== 7'd25) begin n_bad++; $display("FAIL basic_width: got %0d want 25", width_cycles); end
    n_cmp++; if (width_ns !== 10'd250) begin n_bad++; $display("FAIL basic_ns: got %0d want 250", width_ns); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL basic_ov: got %0b want 0", overflow); end
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL basic_accept: got valid=%0b want 0", valid); end
    idle(4);
  endtask

  task automatic test_glitch();
    bit seen;
    ready = 1'b1;
    rep_q.delete();
    pulse(2);
    idle(8);
    n_cmp++; if (rep_q.size() != 0) begin n_bad++; $display("FAIL glitch_reject: got %0d reports want 0", rep_q.size()); end
    pulse(3);
    await_valid(6, seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL glitch_min_valid: got valid=%0b want 1", seen); end
    n_cmp++; if (width_cycles !== 7'd3 || width_ns !== 10'd30) begin n_bad++; $display("FAIL glitch_min_width: got %0d/%0d want 3/30", width_cycles, width_ns); end
    idle(5);
  endtask

  task automatic test_overflow();
    bit seen;
    int first;
    int w;
    bit ov;
    ready = 1'b1;
    pulse(100);
    await_valid(6, seen);
    n_cmp++; if (seen !== 1'b1 || width_cycles !== 7'd100 || overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_max_exact: got seen=%0b w=%0d ov=%0b want 1/100/0", seen, width_cycles, overflow); end
    idle(5);
    first = 0; w = 0; ov = 1'b0;
    sig_in = 1'b1;
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (valid && first == 0) begin
        first = i; w = int'(width_cycles); ov = overflow;
      end
    end
    sig_in = 1'b0;
    n_cmp++; if (first != 103) begin n_bad++; $display("FAIL ovf_edge: got valid at edge %0d want 103", first); end
    n_cmp++; if (w != 100 || ov !== 1'b1) begin n_bad++; $display("FAIL ovf_result: got w=%0d ov=%0b want 100/1", w, ov); end
    rep_q.delete();
    idle(8);
    n_cmp++; if (rep_q.size() != 0) begin n_bad++; $display("FAIL ovf_tail: got %0d reports want 0", rep_q.size()); end
    pulse(10);
    await_valid(6, seen);
    n_cmp++; if (seen !== 1'b1 || width_cycles !== 7'd10 || overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_after: got seen=%0b w=%0d ov=%0b want 1/10/0", seen, width_cycles, overflow); end
    idle(5);
  endtask

  task automatic test_backpressure();
    bit seen;
    bit hold_ok;
    int missed_cnt;
    ready = 1'b0;
    pulse(12);
    await_valid(6, seen);
    n_cmp++; if (seen !== 1'b1 || width_cycles !== 7'd12) begin n_bad++; $display("FAIL bp_first: got seen=%0b w=%0d want 1/12", seen, width_cycles); end
    hold_ok = 1'b1;
    missed_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      sig_in = (i >= 5 && i < 11);
      tick();
      if (missed) missed_cnt++;
      if (!(valid === 1'b1 && width_cycles === 7'd12 && width_ns === 10'd120)) hold_ok = 1'b0;
    end
    sig_in = 1'b0;
    n_cmp++; if (hold_ok !== 1'b1) begin n_bad++; $display("FAIL bp_hold: got outputs changed (w=%0d) want held 12/120", width_cycles); end
    n_cmp++; if (missed_cnt != 1) begin n_bad++; $display("FAIL bp_missed: got %0d pulses want 1", missed_cnt); end
    ready = 1'b1;
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL bp_accept: got valid=%0b want 0", valid); end
    rep_q.delete();
    idle(10);
    n_cmp++; if (rep_q.size() != 0) begin n_bad++; $display("FAIL bp_second: got %0d reports want 0", rep_q.size()); end
  endtask

  task automatic test_enable();
    bit seen;
    ready = 1'b1;
    sig_in = 1'b1;
    repeat (20) tick();
    enable = 1'b0;
    tick();
    n_cmp++; if (valid !== 1'b0 || width_cycles !== 7'd0 || width_ns !== 10'd0 || overflow !== 1'b0 || missed !== 1'b0) begin
      n_bad++; $display("FAIL en_clear: got v=%0b w=%0d ns=%0d ov=%0b m=%0b want all 0", valid, width_cycles, width_ns, overflow, missed);
    end
    repeat (2) tick();
    enable = 1'b1;
    rep_q.delete();
    repeat (30) tick();
    idle(10);
    n_cmp++; if (rep_q.size() != 0) begin n_bad++; $display("FAIL en_inprogress: got %0d reports want 0", rep_q.size()); end
    pulse(8);
    await_valid(6, seen);
    n_cmp++; if (seen !== 1'b1 || width_cycles !== 7'd8) begin n_bad++; $display("FAIL en_next: got seen=%0b w=%0d want 1/8", seen, width_cycles); end
    idle(5);
  endtask

  task automatic test_reset_in_report();
    bit seen;
    ready = 1'b0;
    pulse(5);
    await_valid(6, seen);
    n_cmp++; if (seen !== 1'b1 || width_cycles !== 7'd5) begin n_bad++; $display("FAIL rst_pre: got seen=%0b w=%0d want 1/5", seen, width_cycles); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (valid !== 1'b0 || width_cycles !== 7'd0) begin n_bad++; $display("FAIL rst_report: got v=%0b w=%0d want 0/0", valid, width_cycles); end
    rst_n = 1'b1;
    ready = 1'b1;
    idle(5);
  endtask

  task automatic test_back_to_back();
    ready = 1'b1;
    rep_q.delete();
    pulse(5);
    idle(4);
    pulse(7);
    idle(10);
    n_cmp++; if (rep_q.size() != 2) begin n_bad++; $display("FAIL b2b_count: got %0d reports want 2", rep_q.size()); end
    else begin
      n_cmp++; if (rep_q[0] != 5 || rep_q[1] != 7) begin n_bad++; $display("FAIL b2b_widths: got %0d,%0d want 5,7", rep_q[0], rep_q[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_overflow();
    test_backpressure();
    test_enable();
    test_reset_in_report();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
